// File: rtl/prio_enc8to3_seq.sv
// Registered 8-to-3 priority encoder with request latching.
// Request pulses collect into a pending set. The highest pending index is
// presented over a valid/ready handshake, and the issued bit is cleared on
// acceptance. A saturating counter records how many requests landed on a bit
// that was already pending.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing presented (valid_o=0); idx_o keeps its last value
// PRESENT | idx_o holds a pending index (valid_o=1); frozen until ready_i

module prio_enc8to3_seq #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [2:0]       idx_o,
    output logic [N-1:0]     pend_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] coal_cnt_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pend_q, pend_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] coal_q, coal_d;

    logic             acc;
    logic [N-1:0]     clr;
    logic [N-1:0]     peff;
    logic [N-1:0]     merged;
    logic [2:0]       hi_idx;
    logic [3:0]       merged_cnt;
    logic [CNT_W:0]   coal_sum;

    // Pending set after removing the index accepted this cycle.
    always_comb begin
        acc  = (state_q == PRESENT) && ready_i;
        clr  = acc ? (N'(1) << idx_q) : '0;
        peff = pend_q & ~clr;
    end

    // Highest set bit of peff; lower bits are overwritten by higher ones.
    always_comb begin
        hi_idx = idx_q;
        for (int i = 0; i < N; i++) begin
            if (peff[i]) begin
                hi_idx = 3'(i);
            end
        end
    end

    // Count requests that hit a bit still pending after this cycle's clear.
    always_comb begin
        merged     = req_i & peff;
        merged_cnt = '0;
        for (int i = 0; i < N; i++) begin
            merged_cnt = merged_cnt + {3'b000, merged[i]};
        end
        coal_sum = {1'b0, coal_q} + (CNT_W + 1)'(merged_cnt);
        if (coal_sum > {1'b0, {CNT_W{1'b1}}}) begin
            coal_d = {CNT_W{1'b1}};
        end else begin
            coal_d = coal_sum[CNT_W-1:0];
        end
    end

    // Next pending set, handshake state and presented index.
    always_comb begin
        pend_d  = peff | req_i;
        state_d = state_q;
        idx_d   = idx_q;
        // The output register only reloads when nothing is held or it drains.
        if ((state_q == IDLE) || ready_i) begin
            state_d = (|peff) ? PRESENT : IDLE;
            if (|peff) begin
                idx_d = hi_idx;
            end
        end
    end

    // All state registers; reset discards pending work and any held index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= 3'b000;
            coal_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            coal_q  <= coal_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        valid_o    = (state_q == PRESENT);
        idx_o      = idx_q;
        pend_o     = pend_q;
        coal_cnt_o = coal_q;
        busy_o     = (|pend_q) | (state_q == PRESENT);
    end

endmodule
